// File: rtl/mac_accumulator_pkg.sv
// Shared definitions for the MAC sequencer/accumulator: data width and the
// one-hot state encoding of its control FSM.
package mac_accumulator_pkg;

    localparam int DATA_W  = 32;
    localparam int STATE_W = 5;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 5'b00001,
        ST_ISSUE = 5'b00010,
        ST_WAIT  = 5'b00100,
        ST_ACC   = 5'b01000,
        ST_OUT   = 5'b10000
    } state_e;

    // Low 32 bits of a two's-complement sum; overflow simply wraps.
    function automatic logic [DATA_W-1:0] wrap_add(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        return a + b;
    endfunction

endpackage

// File: rtl/mac_accumulator.sv
// Sequencer/accumulator around a 32x32 sequential multiplier: issues one operand
// pair at a time, sums low products per group, emits one result per group.
// Optional ReLU on the emitted result when MAC_RELU_EN is defined.
module mac_accumulator
    import mac_accumulator_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_a,
    input  logic [31:0]       in_b,
    input  logic              in_first,
    input  logic              in_last,
    input  logic [31:0]       bias_i,
    output logic [31:0]       mul_a,
    output logic [31:0]       mul_b,
    output logic              mul_run,
    input  logic [31:0]       mul_result,
    input  logic              mul_done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic [CNT_W-1:0]  out_count,
    output logic [4:0]        dbg_state
);

    // Handshakes: a transfer happens on a rising clk edge where valid and
    // ready are both high; valid never waits on ready, and out_data/out_count
    // stay stable while out_valid is high and out_ready is low.

    state_e state_q, state_d;

    logic [DATA_W-1:0] mul_a_q, mul_a_d;
    logic [DATA_W-1:0] mul_b_q, mul_b_d;
    logic [DATA_W-1:0] prod_q, prod_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  out_count_q, out_count_d;
    logic              last_q, last_d;
    logic              in_ready_q, in_ready_d;
    logic              mul_run_q, mul_run_d;
    logic              out_valid_q, out_valid_d;

    logic              in_fire;
    logic              out_fire;
    logic [DATA_W-1:0] acc_sum;
    logic [DATA_W-1:0] result_val;
    logic [CNT_W-1:0]  cnt_inc;

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid_q & out_ready;
    assign acc_sum  = wrap_add(acc_q, prod_q);
    assign cnt_inc  = cnt_q + 1'b1;

`ifdef MAC_RELU_EN
    assign result_val = acc_sum[DATA_W-1] ? '0 : acc_sum;
`else
    assign result_val = acc_sum;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (in_fire) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (mul_done) state_d = ST_ACC;
            ST_ACC:   state_d = last_q ? ST_OUT : ST_IDLE;
            ST_OUT:   if (out_fire) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Port strobes are registered from the next state so they line up
    // exactly with the state they belong to and are low during reset.
    always_comb begin
        in_ready_d  = (state_d == ST_IDLE);
        mul_run_d   = (state_d == ST_ISSUE);
        out_valid_d = (state_d == ST_OUT);
    end

    always_comb begin
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        last_d      = last_q;
        prod_d      = prod_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;

        if (state_q == ST_IDLE && in_fire) begin
            mul_a_d = in_a;
            mul_b_d = in_b;
            last_d  = in_last;
            if (in_first) begin
                acc_d = bias_i;
                cnt_d = '0;
            end
        end

        // mul_result is only meaningful alongside mul_done, so capture it here.
        if (state_q == ST_WAIT && mul_done) begin
            prod_d = mul_result;
        end

        if (state_q == ST_ACC) begin
            acc_d = acc_sum;
            cnt_d = cnt_inc;
            if (last_q) begin
                out_data_d  = result_val;
                out_count_d = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            prod_q      <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            last_q      <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
            in_ready_q  <= 1'b0;
            mul_run_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            prod_q      <= prod_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            in_ready_q  <= in_ready_d;
            mul_run_q   <= mul_run_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign mul_run   = mul_run_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_count = out_count_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator paired with a behavioural sequential
// multiplier of adjustable latency.
module tb_mac_accumulator;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_a = '0;
    logic [31:0]      in_b = '0;
    logic             in_first = 1'b0;
    logic             in_last = 1'b0;
    logic [31:0]      bias_i = '0;
    logic [31:0]      mul_a;
    logic [31:0]      mul_b;
    logic             mul_run;
    logic [31:0]      mul_result;
    logic             mul_done;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_data;
    logic [CNT_W-1:0] out_count;
    logic [4:0]       dbg_state;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, got running expected finished");
        $fatal(1);
    end

    mac_accumulator #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_first(in_first), .in_last(in_last), .bias_i(bias_i),
        .mul_a(mul_a), .mul_b(mul_b), .mul_run(mul_run),
        .mul_result(mul_result), .mul_done(mul_done),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_count(out_count),
        .dbg_state(dbg_state)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- multiplier model ----------------
    int          mul_lat = 1;
    int          rem = 0;
    logic [31:0] prod_hold = '0;
    logic [31:0] run_a = '0;
    logic [31:0] run_b = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_done   <= 1'b0;
            mul_result <= '0;
            rem        <= 0;
        end else begin
            mul_done <= 1'b0;
            if (mul_run) begin
                rem       <= mul_lat;
                prod_hold <= 32'(mul_a * mul_b);
                run_a     <= mul_a;
                run_b     <= mul_b;
            end else if (rem > 1) begin
                rem <= rem - 1;
            end else if (rem == 1) begin
                rem        <= 0;
                mul_done   <= 1'b1;
                mul_result <= prod_hold;
            end
        end
    end

    // ---------------- operand monitors ----------------
    logic [31:0] acc_a = '0;
    logic [31:0] acc_b = '0;
    int          run_count = 0;

    always @(posedge clk) begin
        if (rst_n && in_valid && in_ready) begin
            acc_a <= in_a;
            acc_b <= in_b;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (mul_run) begin
                run_count++;
                check_val("mul_a_issue", mul_a, acc_a);
                check_val("mul_b_issue", mul_b, acc_b);
            end
            if (rem > 0) begin
                check_val("mul_a_hold", mul_a, run_a);
                check_val("mul_b_hold", mul_b, run_b);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_pair(input logic [31:0] a, input logic [31:0] b, input logic first,
                             input logic last, input logic [31:0] bias, input logic rand_valid);
        bit ok = 0;
        in_a = a; in_b = b; in_first = first; in_last = last; bias_i = bias;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            in_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            if (in_valid && in_ready) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            in_valid = 1'b0;
            check_val("in_accept_timeout", 32'd0, 32'd1);
        end
    endtask

    task automatic get_result(input string tag, input logic [31:0] exp_data, input logic [31:0] exp_cnt);
        bit ok = 0;
        logic [31:0] exp_d;
        exp_q.push_back(exp_data);
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (out_valid) begin
                exp_d = exp_q.pop_front();
                check_val({tag, "_data"}, out_data, exp_d);
                check_val({tag, "_count"}, 32'(out_count), exp_cnt);
                out_ready = 1'b1;
                @(posedge clk);
                #1;
                out_ready = 1'b0;
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            void'(exp_q.pop_front());
            check_val({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            @(negedge clk);
            check_val({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check_val({tag, "_mul_run"}, 32'(mul_run), 32'd0);
        check_val({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check_val({tag, "_mul_a"}, mul_a, 32'd0);
        check_val({tag, "_mul_b"}, mul_b, 32'd0);
        check_val({tag, "_out_data"}, out_data, 32'd0);
        check_val({tag, "_out_count"}, 32'(out_count), 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    int          runs_before;
    logic [31:0] exp_t1;
    logic [31:0] exp_t7;
    bit          seen;

    initial begin
`ifdef MAC_RELU_EN
        exp_t1 = 32'd0;
        exp_t7 = 32'd0;
`else
        exp_t1 = 32'hFFFF_FFFE;
        exp_t7 = 32'hFFFF_FFFB;
`endif
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_val("idle_ready", 32'(in_ready), 32'd1);

        // single pair, first&last: 10 + 3*(-4) = -2
        mul_lat = 2;
        send_pair(32'd3, 32'hFFFF_FFFC, 1'b1, 1'b1, 32'd10, 1'b0);
        get_result("single", exp_t1, 32'd1);

        // four pairs: 2+12+30+56 = 100
        mul_lat = 3;
        runs_before = run_count;
        send_pair(32'd1, 32'd2, 1'b1, 1'b0, 32'd0, 1'b0);
        send_pair(32'd3, 32'd4, 1'b0, 1'b0, 32'd0, 1'b0);
        send_pair(32'd5, 32'd6, 1'b0, 1'b0, 32'd0, 1'b0);
        send_pair(32'd7, 32'd8, 1'b0, 1'b1, 32'd0, 1'b0);
        get_result("four", 32'd100, 32'd4);
        check_val("four_runs", 32'(run_count - runs_before), 32'd4);

        // output back-pressure for 10 cycles
        mul_lat = 1;
        send_pair(32'd5, 32'd5, 1'b1, 1'b1, 32'd0, 1'b0);
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (out_valid) begin seen = 1; break; end
        end
        check_val("stall_valid_seen", 32'(seen), 32'd1);
        runs_before = run_count;
        for (int i = 0; i < 10; i++) begin
            check_val("stall_data", out_data, 32'd25);
            check_val("stall_valid", 32'(out_valid), 32'd1);
            check_val("stall_in_ready", 32'(in_ready), 32'd0);
            check_val("stall_mul_run", 32'(mul_run), 32'd0);
            @(negedge clk);
        end
        check_val("stall_no_runs", 32'(run_count - runs_before), 32'd0);
        get_result("stall", 32'd25, 32'd1);
        check_val("stall_idle_ready", 32'(in_ready), 32'd1);

        // overflow wraps: 0x7FFFFFFF + 0xFFFFFFFE
        mul_lat = 4;
        send_pair(32'h7FFF_FFFF, 32'd2, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b0);
        get_result("wrap", 32'h7FFF_FFFD, 32'd1);

        // reset asserted while the product is outstanding
        mul_lat = 8;
        send_pair(32'd9, 32'd9, 1'b1, 1'b1, 32'd0, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midwait");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mul_lat = 2;
        send_pair(32'd2, 32'd3, 1'b1, 1'b0, 32'd1, 1'b0);
        send_pair(32'd4, 32'd5, 1'b0, 1'b1, 32'd1, 1'b0);
        get_result("after_reset", 32'd27, 32'd2);

        // no in_first: continues from stale acc 27 and count 2
        send_pair(32'd1, 32'd1, 1'b0, 1'b1, 32'd500, 1'b0);
        get_result("stale", 32'd28, 32'd3);

        // random in_valid toggling: -5 + (-6) + (-10) + 16 = -5
        send_pair(32'hFFFF_FFFE, 32'd3, 1'b1, 1'b0, 32'hFFFF_FFFB, 1'b1);
        send_pair(32'd10, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0, 1'b1);
        send_pair(32'd4, 32'd4, 1'b0, 1'b1, 32'd0, 1'b1);
        get_result("rand_valid", exp_t7, 32'd3);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
